// File: rtl/sigma_arb_pkg.sv
// sigma_arb_pkg: shared types and helpers for the sigma memory arbiter.
//   ID_W        : width of a master id. Sized for the largest supported
//                 master count (8), so one id type serves every N_MASTERS.
//   master_id_t : master index type.
//   rr_next     : round-robin successor of a master id, modulo n.
package sigma_arb_pkg;

    localparam int MAX_MASTERS = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(MAX_MASTERS);

    typedef logic [ID_W-1:0] master_id_t;

    function automatic master_id_t rr_next(input master_id_t id, input int n);
        if (id == master_id_t'(n - 1)) return '0;
        return id + master_id_t'(1);
    endfunction

endpackage

// File: rtl/sigma_mem_arb_rr_pick.sv
// rr_pick: combinational round-robin priority pick.
//   req_i   : request vector, one bit per master
//   ptr_i   : master id holding highest priority this cycle
//   gnt_o   : one-hot grant (all zero when nothing requests)
//   id_o    : granted master id (0 when nothing requests)
//   valid_o : some master was granted
// The request vector is rotated so ptr_i lands on bit 0, the lowest set
// bit is found, and its position is rotated back to an absolute id.
module rr_pick
    import sigma_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    input  master_id_t   ptr_i,
    output logic [N-1:0] gnt_o,
    output master_id_t   id_o,
    output logic         valid_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    master_id_t     pos;
    logic [ID_W:0]  sum;

    always_comb begin
        dbl     = {req_i, req_i} >> ptr_i;
        rot     = dbl[N-1:0];
        pos     = '0;
        valid_o = 1'b0;
        // Descending scan so the lowest rotated position wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos     = master_id_t'(i);
                valid_o = 1'b1;
            end
        end
        sum = {1'b0, pos} + {1'b0, ptr_i};
        if (sum >= (ID_W + 1)'(N)) sum = sum - (ID_W + 1)'(N);
        id_o = sum[ID_W-1:0];
        for (int k = 0; k < N; k++) begin
            gnt_o[k] = valid_o && (id_o == master_id_t'(k));
        end
    end

endmodule

// File: rtl/sigma_mem_arb.sv
// sigma_mem_arb: round-robin arbiter sharing the single-port sigma memory
// between N_MASTERS bus masters. One access per cycle, zero-cycle grant,
// read data returned to the issuing master one cycle after its ack.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   req_i/we_i/addr_i/be_i/
//   wdata_i                     : packed per-master request buses
//   ack_o                       : one-hot, request accepted this cycle
//   resp_o, rdata_o             : one-hot read response and shared data
//   mem_req_o/we/addr/be/wdata  : memory request, muxed from granted master
//   mem_rdata_i                 : memory read data, one cycle after strobe
module sigma_mem_arb
    import sigma_arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_MASTERS-1:0]           req_i,
    input  logic [N_MASTERS-1:0]           we_i,
    input  logic [N_MASTERS*ADDR_W-1:0]    addr_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]  be_i,
    input  logic [N_MASTERS*DATA_W-1:0]    wdata_i,
    output logic [N_MASTERS-1:0]           ack_o,
    output logic [N_MASTERS-1:0]           resp_o,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W/8-1:0]            mem_be_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    input  logic [DATA_W-1:0]              mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    master_id_t           rr_ptr_q, rr_ptr_d;
    logic                 rd_pend_q, rd_pend_d;
    master_id_t           rd_id_q, rd_id_d;

    logic [N_MASTERS-1:0] pick_gnt;
    master_id_t           pick_id;
    logic                 pick_vld;
    logic                 grant;
    logic                 resp_vld;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .id_o    (pick_id),
        .valid_o (pick_vld)
    );

    // Nothing is issued while reset is held.
    assign grant = pick_vld & ~rst_i;
    assign ack_o = grant ? pick_gnt : '0;

    // One-hot AND-OR mux of the granted master's bus; idle drives zeros.
    always_comb begin
        mem_req_o   = grant;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant && pick_gnt[k]) begin
                mem_we_o    = we_i[k];
                mem_addr_o  = addr_i[k*ADDR_W +: ADDR_W];
                mem_be_o    = be_i[k*BE_W +: BE_W];
                mem_wdata_o = wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // A response pending across a reset is dropped, not delivered late.
    assign resp_vld = rd_pend_q & ~rst_i;
    assign rdata_o  = resp_vld ? mem_rdata_i : '0;

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            resp_o[k] = resp_vld && (rd_id_q == master_id_t'(k));
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rd_pend_d = 1'b0;
        rd_id_d   = rd_id_q;
        if (grant) begin
            rr_ptr_d  = rr_next(pick_id, N_MASTERS);
            rd_pend_d = ~mem_we_o;
            if (!mem_we_o) rd_id_d = pick_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

endmodule

// File: tb/tb_sigma_mem_arb.sv
// tb_sigma_mem_arb: directed, table-driven bench for sigma_mem_arb (N=3).
// Each table row is one clock cycle; state carries from row to row.
module tb_sigma_mem_arb;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*4-1:0]  be;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack, resp;
    logic [DW-1:0]   rdata;
    logic            mreq, mwe;
    logic [AW-1:0]   maddr;
    logic [3:0]      mbe;
    logic [DW-1:0]   mwdata;
    logic [DW-1:0]   mrdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sigma_mem_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .be_i        (be),
        .wdata_i     (wdata),
        .ack_o       (ack),
        .resp_o      (resp),
        .rdata_o     (rdata),
        .mem_req_o   (mreq),
        .mem_we_o    (mwe),
        .mem_addr_o  (maddr),
        .mem_be_o    (mbe),
        .mem_wdata_o (mwdata),
        .mem_rdata_i (mrdata)
    );

    typedef struct {
        logic         rst;
        logic [2:0]   req;
        logic [2:0]   we;
        logic [31:0]  mrd;
        logic [2:0]   ack;
        logic [2:0]   resp;
        logic [31:0]  rdata;
        logic         mreq;
        logic         mwe;
        logic [31:0]  maddr;
        logic [3:0]   mbe;
        logic [31:0]  mwdata;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    task automatic drive(input logic r, input logic [2:0] rq, input logic [2:0] w,
                         input logic [31:0] md);
        @(posedge clk);
        #1;
        rst    = r;
        req    = rq;
        we     = w;
        mrdata = md;
        @(negedge clk);
    endtask

    // Fixed per-master buses: m0 0x10, m1 0x100, m2 0x40 (byte 0 only).
    localparam logic [31:0] A0 = 32'h10,       A1 = 32'h100,      A2 = 32'h40;
    localparam logic [31:0] D0 = 32'hA0A0A0A0, D1 = 32'hB1B1B1B1, D2 = 32'h55;

    initial begin
        rst    = 1'b1;
        req    = '0;
        we     = '0;
        mrdata = '0;
        addr   = {A2, A1, A0};
        be     = {4'b0001, 4'hF, 4'hF};
        wdata  = {D2, D1, D0};

        //            rst req     we      mrd            ack     resp    rdata          mreq mwe maddr mbe   mwdata
        vq.push_back('{1, 3'b111, 3'b000, 32'h0,        3'b000, 3'b000, 32'h0,         0, 0, 32'h0, 4'h0, 32'h0});
        vq.push_back('{1, 3'b000, 3'b000, 32'h0,        3'b000, 3'b000, 32'h0,         0, 0, 32'h0, 4'h0, 32'h0});
        // single read by master 1
        vq.push_back('{0, 3'b010, 3'b000, 32'h0,        3'b010, 3'b000, 32'h0,         1, 0, A1,    4'hF, D1});
        vq.push_back('{0, 3'b000, 3'b000, 32'hDEADBEEF, 3'b000, 3'b010, 32'hDEADBEEF,  0, 0, 32'h0, 4'h0, 32'h0});
        vq.push_back('{0, 3'b000, 3'b000, 32'h12345678, 3'b000, 3'b000, 32'h0,         0, 0, 32'h0, 4'h0, 32'h0});
        // pointer at 2, masters 0 and 1 request: 0 then 1
        vq.push_back('{0, 3'b011, 3'b000, 32'h0,        3'b001, 3'b000, 32'h0,         1, 0, A0,    4'hF, D0});
        vq.push_back('{0, 3'b010, 3'b000, 32'hCAFEF00D, 3'b010, 3'b001, 32'hCAFEF00D,  1, 0, A1,    4'hF, D1});
        // master 2 byte write, overlapping master 1's read response
        vq.push_back('{0, 3'b100, 3'b100, 32'h11111111, 3'b100, 3'b010, 32'h11111111,  1, 1, A2,    4'h1, D2});
        vq.push_back('{0, 3'b000, 3'b000, 32'h22222222, 3'b000, 3'b000, 32'h0,         0, 0, 32'h0, 4'h0, 32'h0});
        // all masters requesting reads
        vq.push_back('{0, 3'b111, 3'b000, 32'h0,        3'b001, 3'b000, 32'h0,         1, 0, A0,    4'hF, D0});
        vq.push_back('{0, 3'b111, 3'b000, 32'hAAAA0001, 3'b010, 3'b001, 32'hAAAA0001,  1, 0, A1,    4'hF, D1});
        vq.push_back('{0, 3'b111, 3'b000, 32'hAAAA0002, 3'b100, 3'b010, 32'hAAAA0002,  1, 0, A2,    4'h1, D2});
        vq.push_back('{0, 3'b111, 3'b000, 32'hAAAA0003, 3'b001, 3'b100, 32'hAAAA0003,  1, 0, A0,    4'hF, D0});
        vq.push_back('{0, 3'b111, 3'b000, 32'hAAAA0004, 3'b010, 3'b001, 32'hAAAA0004,  1, 0, A1,    4'hF, D1});
        // reset the cycle after master 1's read ack: response dropped
        vq.push_back('{1, 3'b111, 3'b000, 32'hAAAA0005, 3'b000, 3'b000, 32'h0,         0, 0, 32'h0, 4'h0, 32'h0});
        vq.push_back('{0, 3'b111, 3'b000, 32'hAAAA0006, 3'b001, 3'b000, 32'h0,         1, 0, A0,    4'hF, D0});
        vq.push_back('{0, 3'b000, 3'b000, 32'hCCCC0001, 3'b000, 3'b001, 32'hCCCC0001,  0, 0, 32'h0, 4'h0, 32'h0});
        // master 0 raises during master 1's grant, then withdraws
        vq.push_back('{0, 3'b011, 3'b000, 32'h0,        3'b010, 3'b000, 32'h0,         1, 0, A1,    4'hF, D1});
        vq.push_back('{0, 3'b000, 3'b000, 32'hDDDD0001, 3'b000, 3'b010, 32'hDDDD0001,  0, 0, 32'h0, 4'h0, 32'h0});
        // pointer held at 2 across the idle cycle: master 2 wins over 1
        vq.push_back('{0, 3'b110, 3'b000, 32'h0,        3'b100, 3'b000, 32'h0,         1, 0, A2,    4'h1, D2});
        vq.push_back('{0, 3'b000, 3'b000, 32'hEEEE0001, 3'b000, 3'b100, 32'hEEEE0001,  0, 0, 32'h0, 4'h0, 32'h0});

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].req, vq[i].we, vq[i].mrd);
            chk("ack",    i, 32'(ack),    32'(vq[i].ack));
            chk("resp",   i, 32'(resp),   32'(vq[i].resp));
            chk("rdata",  i, rdata,       vq[i].rdata);
            chk("mreq",   i, 32'(mreq),   32'(vq[i].mreq));
            chk("mwe",    i, 32'(mwe),    32'(vq[i].mwe));
            chk("maddr",  i, maddr,       vq[i].maddr);
            chk("mbe",    i, 32'(mbe),    32'(vq[i].mbe));
            chk("mwdata", i, mwdata,      vq[i].mwdata);
        end

        // Fairness: pointer is 0 here; continuous reads rotate 0,1,2 and
        // each response trails its ack by one cycle.
        for (int i = 0; i < 9; i++) begin
            logic [2:0]  e_ack, e_resp;
            logic [31:0] md;
            md     = 32'hF0000000 + 32'(i);
            e_ack  = 3'b001 << (i % 3);
            e_resp = (i == 0) ? 3'b000 : 3'b001 << ((i - 1) % 3);
            drive(1'b0, 3'b111, 3'b000, md);
            chk("fair_ack",   100 + i, 32'(ack),  32'(e_ack));
            chk("fair_resp",  100 + i, 32'(resp), 32'(e_resp));
            chk("fair_rdata", 100 + i, rdata,     (i == 0) ? 32'h0 : md);
        end

        // Write by master 2 (pointer back at 0, only 2 requests), then idle:
        // the read from the last fairness cycle answers, the write does not.
        drive(1'b0, 3'b100, 3'b100, 32'h13579BDF);
        chk("wr_ack",  200, 32'(ack),  32'(3'b100));
        chk("wr_mwe",  200, 32'(mwe),  32'h1);
        chk("wr_resp", 200, 32'(resp), 32'(3'b100));
        drive(1'b0, 3'b000, 3'b000, 32'h2468ACE0);
        chk("wr_noresp", 201, 32'(resp),  32'h0);
        chk("wr_rdata",  201, rdata,      32'h0);
        chk("wr_idle",   201, 32'(mreq),  32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
